// File: rtl/mbinit_reversalmb_if.sv
// mbinit_reversalmb_if: sideband, pattern and status signals between the link-training sequencer and MBINIT.REVERSALMB
interface mbinit_reversalmb_if;
    logic        i_MBINIT_REPAIRVAL_end;
    logic [3:0]  i_RX_SbMessage;
    logic        i_msg_valid;
    logic [15:0] i_RX_Result;
    logic        i_falling_edge_busy;
    logic        i_pattern_done;
    logic [3:0]  o_TX_SbMessage;
    logic        o_ValidOutData_REVERSALMB;
    logic        o_pattern_en;
    logic        o_lane_reversal_en;
    logic        o_MBINIT_REVERSALMB_end;
    logic        o_train_error;
    modport slave (
        input  i_MBINIT_REPAIRVAL_end, i_RX_SbMessage, i_msg_valid, i_RX_Result,
               i_falling_edge_busy, i_pattern_done,
        output o_TX_SbMessage, o_ValidOutData_REVERSALMB, o_pattern_en,
               o_lane_reversal_en, o_MBINIT_REVERSALMB_end, o_train_error
    );
    modport master (
        output i_MBINIT_REPAIRVAL_end, i_RX_SbMessage, i_msg_valid, i_RX_Result,
               i_falling_edge_busy, i_pattern_done,
        input  o_TX_SbMessage, o_ValidOutData_REVERSALMB, o_pattern_en,
               o_lane_reversal_en, o_MBINIT_REVERSALMB_end, o_train_error
    );
endinterface

// File: rtl/mbinit_reversalmb.sv
// mbinit_reversalmb: MBINIT.REVERSALMB initiator controller with one lane-reversal retry.
// Define REVERSALMB_TIMEOUT_EN to add a per-state sideband watchdog that forces ERROR.
module mbinit_reversalmb #(
    parameter int TIMEOUT_CYCLES = 8_000_000,
    parameter int PASS_MIN       = 9
) (
    input logic                CLK,
    input logic                rst,
    mbinit_reversalmb_if.slave bus
);
    localparam logic [3:0] INIT_REQ = 4'd1, INIT_RESP = 4'd2, CLR_REQ = 4'd3, CLR_RESP = 4'd4;
    localparam logic [3:0] RESULT_REQ = 4'd5, RESULT_RESP = 4'd6, DONE_REQ = 4'd7, DONE_RESP = 4'd8;

    typedef enum logic [3:0] {
        IDLE, SEND_INIT, WAIT_INIT, SEND_CLR, WAIT_CLR, PATTERN, SEND_RESULT,
        WAIT_RESULT, EVAL, SEND_DONE, WAIT_DONE, DONE, ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] res_q, res_d;
    logic        rev_q, rev_d;
    logic [4:0]  pop;
    logic [3:0]  exp_code;
    logic        start, fe, hit;

    assign start = bus.i_MBINIT_REPAIRVAL_end;
    assign fe    = bus.i_falling_edge_busy;
    assign exp_code = state_q inside {SEND_INIT, WAIT_INIT}     ? INIT_RESP :
                      state_q inside {SEND_CLR, WAIT_CLR}       ? CLR_RESP :
                      state_q inside {SEND_RESULT, WAIT_RESULT} ? RESULT_RESP :
                      state_q inside {SEND_DONE, WAIT_DONE}     ? DONE_RESP : 4'd0;
    assign hit = bus.i_msg_valid && bus.i_RX_SbMessage == exp_code;

    always_comb begin
        pop = 5'd0;
        for (int i = 0; i < 16; i++) pop = pop + {4'd0, res_q[i]};
    end

`ifdef REVERSALMB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timed;
    assign timed = state_q inside {SEND_INIT, WAIT_INIT, SEND_CLR, WAIT_CLR, PATTERN,
                                   SEND_RESULT, WAIT_RESULT, SEND_DONE, WAIT_DONE};
    assign cnt_d = (!timed || state_d != state_q) ? '0 : cnt_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rev_d   = rev_q;
        case (state_q)
            IDLE:        if (start) begin
                             state_d = SEND_INIT;
                             rev_d   = 1'b0;
                         end
            SEND_INIT:   if (fe) state_d = hit ? SEND_CLR : WAIT_INIT;
            WAIT_INIT:   if (hit) state_d = SEND_CLR;
            SEND_CLR:    if (fe) state_d = hit ? PATTERN : WAIT_CLR;
            WAIT_CLR:    if (hit) state_d = PATTERN;
            PATTERN:     if (bus.i_pattern_done) state_d = SEND_RESULT;
            SEND_RESULT: if (fe) state_d = hit ? EVAL : WAIT_RESULT;
            WAIT_RESULT: if (hit) state_d = EVAL;
            EVAL:        if (pop >= 5'(PASS_MIN)) state_d = SEND_DONE;
                         else if (rev_q) state_d = ERROR;
                         else begin
                             state_d = SEND_CLR;
                             rev_d   = 1'b1;
                         end
            SEND_DONE:   if (fe) state_d = hit ? DONE : WAIT_DONE;
            WAIT_DONE:   if (hit) state_d = DONE;
            default:     ;
        endcase
        // Result is latched both from WAIT_RESULT and from a response that coincides with the TX falling edge
        if (hit && (state_q == WAIT_RESULT || (state_q == SEND_RESULT && fe))) res_d = bus.i_RX_Result;
`ifdef REVERSALMB_TIMEOUT_EN
        if (timed && cnt_q == CW'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
`endif
        if (state_q != IDLE && !start) state_d = IDLE;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            rev_q   <= 1'b0;
`ifdef REVERSALMB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rev_q   <= rev_d;
`ifdef REVERSALMB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.o_TX_SbMessage = state_q == SEND_INIT   ? INIT_REQ :
                                state_q == SEND_CLR    ? CLR_REQ :
                                state_q == SEND_RESULT ? RESULT_REQ :
                                state_q == SEND_DONE   ? DONE_REQ : 4'd0;
    assign bus.o_ValidOutData_REVERSALMB = state_q inside {SEND_INIT, SEND_CLR, SEND_RESULT, SEND_DONE};
    assign bus.o_pattern_en            = state_q == PATTERN;
    assign bus.o_lane_reversal_en      = rev_q;
    assign bus.o_MBINIT_REVERSALMB_end = state_q == DONE;
    assign bus.o_train_error           = state_q == ERROR;
endmodule

// File: tb/tb_mbinit_reversalmb.sv
// tb_mbinit_reversalmb: directed scoreboard bench; stimulus pushes expected TX/terminal events, a monitor pops and compares.
module tb_mbinit_reversalmb;
    localparam logic [3:0] INIT_REQ = 4'd1, INIT_RESP = 4'd2, CLR_REQ = 4'd3, CLR_RESP = 4'd4;
    localparam logic [3:0] RESULT_REQ = 4'd5, RESULT_RESP = 4'd6, DONE_REQ = 4'd7, DONE_RESP = 4'd8;

    typedef struct {
        bit         term;
        logic [3:0] code;
        logic       e;
        logic       er;
        logic       rv;
    } exp_t;

    typedef struct {
        logic [15:0] r1;
        logic [15:0] r2;
        bit          retry;
        logic        e;
        logic        er;
        logic        rv;
        bit          coinc;
        bit          stray;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic pv = 1'b0, pt = 1'b0;
    logic [3:0] pc = 4'd0;

    mbinit_reversalmb_if bus();
    mbinit_reversalmb #(.TIMEOUT_CYCLES(100), .PASS_MIN(9)) dut (.CLK(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input bit term, input logic [3:0] code, input logic e, input logic er, input logic rv);
        exp_t x;
        x.term = term; x.code = code; x.e = e; x.er = er; x.rv = rv;
        sb.push_back(x);
    endfunction

    function automatic void pop_chk(input bit term);
        exp_t x;
        if (sb.size() == 0) begin
            chk(term ? "unexpected_term" : "unexpected_tx", 32'(term), 32'hdead);
            return;
        end
        x = sb.pop_front();
        chk("event_kind", 32'(term), 32'(x.term));
        if (term) begin
            chk("term_end", 32'(bus.o_MBINIT_REVERSALMB_end), 32'(x.e));
            chk("term_err", 32'(bus.o_train_error), 32'(x.er));
        end else
            chk("tx_code", 32'(bus.o_TX_SbMessage), 32'(x.code));
        chk(term ? "term_rev" : "tx_rev", 32'(bus.o_lane_reversal_en), 32'(x.rv));
    endfunction

    initial forever begin
        @(negedge clk);
        if (bus.o_ValidOutData_REVERSALMB && (!pv || bus.o_TX_SbMessage != pc)) pop_chk(1'b0);
        if ((bus.o_MBINIT_REVERSALMB_end || bus.o_train_error) && !pt) pop_chk(1'b1);
        pv = bus.o_ValidOutData_REVERSALMB;
        pc = bus.o_TX_SbMessage;
        pt = bus.o_MBINIT_REVERSALMB_end || bus.o_train_error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int kind, input string name);
        for (int n = 0; n < 100; n++) begin
            if (kind == 0 && bus.o_ValidOutData_REVERSALMB) return;
            if (kind == 1 && bus.o_pattern_en) return;
            if (kind == 2 && (bus.o_MBINIT_REVERSALMB_end || bus.o_train_error)) return;
            tick();
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic handshake(input logic [3:0] resp, input logic [15:0] r, input bit coinc, input bit stray, input bit answer);
        wait_until(0, "tx_valid");
        tick();
        bus.i_falling_edge_busy = 1'b1;
        if (coinc && answer) begin
            bus.i_msg_valid = 1'b1; bus.i_RX_SbMessage = resp; bus.i_RX_Result = r;
        end
        tick();
        bus.i_falling_edge_busy = 1'b0;
        bus.i_msg_valid = 1'b0;
        if (coinc || !answer) return;
        if (stray) begin
            bus.i_msg_valid = 1'b1; bus.i_RX_SbMessage = CLR_RESP;
            tick();
            bus.i_msg_valid = 1'b0;
            tick();
        end
        bus.i_msg_valid = 1'b1; bus.i_RX_SbMessage = resp; bus.i_RX_Result = r;
        tick();
        bus.i_msg_valid = 1'b0; bus.i_RX_SbMessage = 4'd0;
    endtask

    task automatic pattern();
        wait_until(1, "pattern_en");
        tick();
        bus.i_pattern_done = 1'b1;
        tick();
        bus.i_pattern_done = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bus.i_MBINIT_REPAIRVAL_end = 1'b1;
        push(0, INIT_REQ, 0, 0, 0);   handshake(INIT_RESP, 16'h0, v.coinc, v.stray, 1);
        push(0, CLR_REQ, 0, 0, 0);    handshake(CLR_RESP, 16'h0, v.coinc, 0, 1);
        pattern();
        push(0, RESULT_REQ, 0, 0, 0); handshake(RESULT_RESP, v.r1, v.coinc, 0, 1);
        if (v.retry) begin
            push(0, CLR_REQ, 0, 0, 1);    handshake(CLR_RESP, 16'h0, v.coinc, 0, 1);
            pattern();
            push(0, RESULT_REQ, 0, 0, 1); handshake(RESULT_RESP, v.r2, v.coinc, 0, 1);
        end
        if (v.e) begin
            push(0, DONE_REQ, 0, 0, v.rv); handshake(DONE_RESP, 16'h0, v.coinc, 0, 1);
        end
        push(1, 4'd0, v.e, v.er, v.rv);
        wait_until(2, "terminal");
        tick();
        bus.i_MBINIT_REPAIRVAL_end = 1'b0;
        tick();
        tick();
        chk("idle_end", 32'(bus.o_MBINIT_REVERSALMB_end), 32'd0);
        chk("idle_err", 32'(bus.o_train_error), 32'd0);
        chk("idle_valid", 32'(bus.o_ValidOutData_REVERSALMB), 32'd0);
        chk("idle_rev_kept", 32'(bus.o_lane_reversal_en), 32'(v.rv));
    endtask

    vec_t vecs[5] = '{
        '{16'hFFFF, 16'h0000, 0, 1, 0, 0, 0, 0},
        '{16'h00FF, 16'hFFFF, 1, 1, 0, 1, 0, 1},
        '{16'h0001, 16'h00FF, 1, 0, 1, 1, 0, 0},
        '{16'h01FF, 16'h0000, 0, 1, 0, 0, 1, 0},
        '{16'h00FF, 16'h01FF, 1, 1, 0, 1, 1, 0}
    };

    initial begin
        bus.i_MBINIT_REPAIRVAL_end = 1'b0;
        bus.i_RX_SbMessage = 4'd0;
        bus.i_msg_valid = 1'b0;
        bus.i_RX_Result = 16'h0;
        bus.i_falling_edge_busy = 1'b0;
        bus.i_pattern_done = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(bus.o_ValidOutData_REVERSALMB), 32'd0);
        chk("reset_code", 32'(bus.o_TX_SbMessage), 32'd0);
        chk("reset_pattern", 32'(bus.o_pattern_en), 32'd0);
        chk("reset_rev", 32'(bus.o_lane_reversal_en), 32'd0);
        chk("reset_end", 32'(bus.o_MBINIT_REVERSALMB_end), 32'd0);
        chk("reset_err", 32'(bus.o_train_error), 32'd0);
        rst = 1'b0;
        tick();
        foreach (vecs[k]) run_vec(vecs[k]);

        // start dropped while the pattern burst is running
        bus.i_MBINIT_REPAIRVAL_end = 1'b1;
        push(0, INIT_REQ, 0, 0, 0); handshake(INIT_RESP, 16'h0, 0, 0, 1);
        push(0, CLR_REQ, 0, 0, 0);  handshake(CLR_RESP, 16'h0, 0, 0, 1);
        wait_until(1, "pattern_en");
        chk("pattern_en_on", 32'(bus.o_pattern_en), 32'd1);
        bus.i_MBINIT_REPAIRVAL_end = 1'b0;
        tick();
        chk("drop_pattern_en", 32'(bus.o_pattern_en), 32'd0);
        chk("drop_valid", 32'(bus.o_ValidOutData_REVERSALMB), 32'd0);
        tick();

        // asynchronous reset while waiting for the retry RESULT_RESP
        bus.i_MBINIT_REPAIRVAL_end = 1'b1;
        push(0, INIT_REQ, 0, 0, 0);   handshake(INIT_RESP, 16'h0, 0, 0, 1);
        push(0, CLR_REQ, 0, 0, 0);    handshake(CLR_RESP, 16'h0, 0, 0, 1);
        pattern();
        push(0, RESULT_REQ, 0, 0, 0); handshake(RESULT_RESP, 16'h00FF, 0, 0, 1);
        push(0, CLR_REQ, 0, 0, 1);    handshake(CLR_RESP, 16'h0, 0, 0, 1);
        pattern();
        push(0, RESULT_REQ, 0, 0, 1); handshake(RESULT_RESP, 16'h0, 0, 0, 0);
        chk("pre_reset_rev", 32'(bus.o_lane_reversal_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rev", 32'(bus.o_lane_reversal_en), 32'd0);
        chk("midrst_valid", 32'(bus.o_ValidOutData_REVERSALMB), 32'd0);
        chk("midrst_end_err", 32'({bus.o_MBINIT_REVERSALMB_end, bus.o_train_error, bus.o_pattern_en}), 32'd0);
        bus.i_MBINIT_REPAIRVAL_end = 1'b0;
        tick();
        rst = 1'b0;
        tick();

`ifdef REVERSALMB_TIMEOUT_EN
        begin
            int n;
            bus.i_MBINIT_REPAIRVAL_end = 1'b1;
            push(0, INIT_REQ, 0, 0, 0);
            handshake(INIT_RESP, 16'h0, 0, 0, 0);
            push(1, 4'd0, 0, 1, 0);
            n = 0;
            while (!bus.o_train_error && n < 300) begin
                tick();
                n++;
            end
            chk("timeout_cycles", 32'(n), 32'd100);
            tick();
            bus.i_MBINIT_REPAIRVAL_end = 1'b0;
            tick();
        end
`endif
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
